// File: rtl/if_mem_fetch.sv
// if_mem_fetch: instruction fetch responder reading a 32-bit word as four bytes from a byte-wide RAM
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   pc_i, ce_i       fetch byte address and request (sampled only while idle)
//   flush_i          abort the in-flight fetch and drop any request on the same edge
//   busy_o           fetch in flight; the PC stage holds pc_i
//   inst_o           assembled little-endian word, qualified by inst_valid_o
//   inst_valid_o     one-cycle pulse when inst_o holds the requested word
//   mem_a_o          registered RAM byte address
//   mem_din_i        RAM byte for the address presented on the previous edge
// Optional macro ICACHE_EN adds a direct-mapped one-word-per-line instruction cache.
module if_mem_fetch #(
    parameter int ADDR_W       = 17,
    parameter int ICACHE_LINES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_i,
    input  logic              ce_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] mem_a_o,
    input  logic [7:0]        mem_din_i
);
    localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, CAP = 2'd2;
    logic [1:0]        state;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] pc_r;
    logic              hit;
    logic [31:0]       hit_word;
    logic              unused_ok;
    assign unused_ok = ^{pc_i[31:ADDR_W], 32'(ICACHE_LINES)};
`ifdef ICACHE_EN
    localparam int IW = $clog2(ICACHE_LINES);
    logic [31:0]          line_data [ICACHE_LINES];
    logic [ADDR_W-IW-3:0] line_tag  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] line_vld;
    logic [IW-1:0]        ridx, widx;
    logic                 fill;
    assign ridx     = pc_i[IW+1:2];
    assign widx     = pc_r[IW+1:2];
    // only aligned addresses can live in the cache
    assign hit      = state == IDLE && ce_i && !flush_i && pc_i[1:0] == 2'b00 &&
                      line_vld[ridx] && line_tag[ridx] == pc_i[ADDR_W-1:IW+2];
    assign hit_word = line_data[ridx];
    // fill on the final capture edge unless that edge is flushed
    assign fill     = state == CAP && !flush_i && pc_r[1:0] == 2'b00;
    always_ff @(posedge clk) begin
        if (!rst)
            line_vld <= '0;
        else if (fill)
            line_vld[widx] <= 1'b1;
    end
    always_ff @(posedge clk) begin
        if (fill) begin
            line_data[widx] <= {mem_din_i, inst_o[23:0]};
            line_tag[widx]  <= pc_r[ADDR_W-1:IW+2];
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_word = '0;
`endif
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            busy_o       <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            mem_a_o      <= '0;
            pc_r         <= '0;
        end else begin
            inst_valid_o <= 1'b0;
            if (flush_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else if (state == IDLE) begin
                if (hit) begin
                    inst_o       <= hit_word;
                    inst_valid_o <= 1'b1;
                end else if (ce_i) begin
                    pc_r    <= pc_i[ADDR_W-1:0];
                    mem_a_o <= pc_i[ADDR_W-1:0];
                    busy_o  <= 1'b1;
                    cnt     <= '0;
                    state   <= RD;
                end
            end else if (state == RD) begin
                // cnt==n: issue pc+n+1 (n<3) and capture the byte of pc+n-1 (n>0)
                if (cnt != 2'd3)
                    mem_a_o <= pc_r + ADDR_W'({1'b0, cnt} + 3'd1);
                if (cnt != 2'd0)
                    inst_o[{cnt - 2'd1, 3'b000} +: 8] <= mem_din_i;
                cnt <= cnt + 2'd1;
                if (cnt == 2'd3)
                    state <= CAP;
            end else if (state == CAP) begin
                inst_o[31:24] <= mem_din_i;
                inst_valid_o  <= 1'b1;
                busy_o        <= 1'b0;
                state         <= IDLE;
            end else begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_if_mem_fetch.sv
// tb_if_mem_fetch: table-driven and scoreboarded checks of the byte-serial fetch responder
module tb_if_mem_fetch;
    localparam int AW = 17;
    logic          clk = 1'b0, rst = 1'b0, ce = 1'b0, flush = 1'b0;
    logic [31:0]   pc = '0;
    logic          busy, valid;
    logic [31:0]   inst;
    logic [AW-1:0] mem_a;
    logic [7:0]    mem_din;
    logic [7:0]    ram [1<<AW];
    int            n_cmp = 0, n_bad = 0;
    logic [31:0]   sb [$];
    logic [AW-1:0] addr [4];
    int            lat;
    typedef struct { logic [31:0] pc; logic [31:0] exp; } vec_t;
    vec_t          vecs [6];

    always #5 clk = ~clk;

    if_mem_fetch #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .pc_i(pc), .ce_i(ce), .flush_i(flush),
        .busy_o(busy), .inst_o(inst), .inst_valid_o(valid),
        .mem_a_o(mem_a), .mem_din_i(mem_din)
    );

    always @(posedge clk) mem_din <= ram[mem_a];

    function automatic logic [31:0] word(input logic [31:0] p);
        logic [AW-1:0] a0, a1, a2, a3;
        a0 = p[AW-1:0];
        a1 = a0 + 1'b1;
        a2 = a0 + 2'd2;
        a3 = a0 + 2'd3;
        return {ram[a3], ram[a2], ram[a1], ram[a0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_valid: got pulse with inst %h, want none", inst);
            end else
                check("inst", inst, sb.pop_front());
        end
    end

    task automatic fetch(input logic [31:0] p, input logic [31:0] exp);
        @(negedge clk);
        pc = p;
        ce = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1 ce = 1'b0;
        addr[0] = mem_a;
        lat = 0;
        while (!valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
            if (lat < 4) addr[lat] = mem_a;
        end
        check("fetch_done", {31'b0, valid}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int p1, p2, lowc;
        logic [AW-1:0] saved;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 8'((i * 37 + 11) ^ (i >> 7));
        ram[17'h100] = 8'h13; ram[17'h101] = 8'h05; ram[17'h102] = 8'hA0; ram[17'h103] = 8'h00;
        ram[17'h1FFFE] = 8'hEF; ram[17'h1FFFF] = 8'hBE; ram[17'h0] = 8'hAD; ram[17'h1] = 8'hDE;
        vecs[0].pc = 32'h104;      vecs[1].pc = 32'h105;  vecs[2].pc = 32'h7FC;
        vecs[3].pc = 32'h1236;     vecs[4].pc = 32'hFFFE0200; vecs[5].pc = 32'h803;
        for (int i = 0; i < 6; i++) vecs[i].exp = word(vecs[i].pc);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_valid", {31'b0, valid}, 0);
        check("rst_inst", inst, 0);
        check("rst_addr", 32'(mem_a), 0);
        @(negedge clk) rst = 1'b1;
        fetch(32'h100, 32'h00A00513);
        check("t1_lat", lat, 5);
        for (int i = 0; i < 4; i++) check("t1_addr", 32'(addr[i]), 32'h100 + i);
        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i].pc, vecs[i].exp);
            check("vec_lat", lat, 5);
        end
        fetch(32'h1FFFE, 32'hDEADBEEF);
        check("wrap_a0", 32'(addr[0]), 32'h1FFFE);
        check("wrap_a1", 32'(addr[1]), 32'h1FFFF);
        check("wrap_a2", 32'(addr[2]), 32'h0);
        check("wrap_a3", 32'(addr[3]), 32'h1);
        @(negedge clk);
        pc = 32'h0;
        ce = 1'b1;
        sb.push_back(word(32'h0));
        @(posedge clk);
        #1 pc = 32'h4;
        sb.push_back(word(32'h4));
        p1 = 0; p2 = 0; lowc = 0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk);
            #1;
            if (i == 6) ce = 1'b0;
            if (valid) begin
                if (p1 == 0) p1 = i;
                else p2 = i;
            end
            if (i <= 10 && !busy) lowc++;
            if (i == 5) check("b2b_hold_addr", 32'(mem_a), 32'h3);
        end
        check("b2b_pulse1", p1, 5);
        check("b2b_pulse2", p2, 11);
        check("b2b_idle_cycles", lowc, 1);
        @(negedge clk);
        pc = 32'h8;
        ce = 1'b1;
        @(posedge clk);
        #1 ce = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 0);
        check("flush_valid", {31'b0, valid}, 0);
        repeat (8) @(posedge clk);
        fetch(32'h20, word(32'h20));
        check("flush_next_lat", lat, 5);
        @(negedge clk);
        pc = 32'h30;
        ce = 1'b1;
        @(posedge clk);
        #1 ce = 1'b0;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_valid", {31'b0, valid}, 0);
        check("mid_rst_inst", inst, 0);
        check("mid_rst_addr", 32'(mem_a), 0);
        @(negedge clk) rst = 1'b1;
        repeat (8) @(posedge clk);
        fetch(32'h30, word(32'h30));
        check("post_rst_lat", lat, 5);
`ifdef ICACHE_EN
        fetch(32'h40, word(32'h40));
        check("c_miss_lat", lat, 5);
        saved = mem_a;
        fetch(32'h40, word(32'h40));
        check("c_hit_lat", lat, 0);
        check("c_hit_addr", 32'(addr[0]), 32'(saved));
        fetch(32'h140, word(32'h140));
        check("c_evict_lat", lat, 5);
        fetch(32'h40, word(32'h40));
        check("c_remiss_lat", lat, 5);
`else
        saved = mem_a;
        fetch(32'h40, word(32'h40));
        check("nocache_lat", lat, 5);
        fetch(32'h40, word(32'h40));
        check("nocache_again_lat", lat, 5);
        check("nocache_addr", 32'(addr[0]), 32'h40);
`endif
        repeat (4) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
